approx_add_pipe: RTL and testbench
==================================

// Module: approx_add_pipe
// PURPOSE
//   Parametrised, pipelined unsigned adder. The approximation mode and the number of
//   approximate low bits are selectable per operand, at run time.
//   Uses a valid/ready handshake and carries an exact shadow sum down the pipe.
//   An on-line error monitor counts erroneous results and tracks the worst-case error.
//   Sits between operand sources and accumulators where energy and accuracy trade-offs
//   are evaluated in-system.
// PARAMETERS
//   WIDTH       8   operand width; the sum is WIDTH+1 bits
//   APPROX_MAX  4   maximum approximate low bits (1..WIDTH-1)
//   STAGES      2   pipeline register stages (1..4) = latency in cycles
//   CNT_W       16  width of the error-event counter
// PORTS
//   clk        in   1              clock, rising edge
//   rst        in   1              asynchronous reset, active-high
//   in_valid   in   1              operand beat valid
//   in_ready   out  1              block accepts a beat this cycle
//   in_a       in   WIDTH          operand A
//   in_b       in   WIDTH          operand B
//   in_mode    in   2              0 EXACT, 1 LOA, 2 TRUNC, 3 reserved (treated as EXACT)
//   in_k       in   clog2(APPROX_MAX+1)   approximate low-bit count, sampled with operands
//   out_valid  out  1              result valid
//   out_ready  in   1              downstream accepts result
//   out_sum    out  WIDTH+1        approximate sum
//   out_err    out  WIDTH+1        |exact - approximate| for this result
//   stats_clr  in   1              synchronous clear of the statistics
//   err_cnt    out  CNT_W          number of delivered results with out_err != 0 (saturating)
//   err_max    out  WIDTH+1        largest out_err delivered since reset or clear
// BEHAVIOUR
//   - Reset: all stage valids = 0; out_valid, out_sum, out_err, err_cnt, err_max = 0.
//     Reset mid-operation discards every in-flight beat.
//   - Handshake: adv = ~out_valid | out_ready; in_ready = adv.
//     Beat accepted when in_valid & in_ready. Delivered when out_valid & out_ready.
//   - Stall is global: all stages hold while adv = 0. Bubbles are not collapsed.
//     out_* stay stable while out_valid & ~out_ready.
//   - Latency: a beat accepted in cycle t appears on out_* in cycle t+STAGES
//     if there are no stalls. Throughput is 1 beat per cycle.
//   - k_eff = min(in_k, APPROX_MAX). Mode 0, mode 3, or k_eff = 0 gives the exact sum, err 0.
//   - LOA mode:
//       sum[k-1:0] = a[k-1:0] | b[k-1:0]
//       cin = a[k-1] & b[k-1]
//       sum[WIDTH:k] = a[W-1:k] + b[W-1:k] + cin
//   - TRUNC mode:
//       sum[k-1:0] = 0
//       sum[WIDTH:k] = a[W-1:k] + b[W-1:k]   (no carry-in)
//   - Datapath: approximate and exact sums are computed combinationally in stage 0.
//     out_err = exact - approx if exact >= approx, else approx - exact.
//     It is registered in the final stage and stays aligned with out_sum.
//   - Stats update only on delivery:
//       err_cnt += (out_err != 0), saturating at all-ones
//       err_max = max(err_max, out_err)
//   - stats_clr has priority over a same-cycle delivery: both stats go to 0 and that
//     delivery is not counted. Clear does not affect the data pipe.
//   - mode/k are per-beat; changing them between beats never corrupts in-flight results.
// STRUCTURE
//   - Package approx_add_pkg:
//       mode enum (MODE_EXACT, MODE_LOA, MODE_TRUNC, MODE_RSVD)
//       function clog2
//   - Sub-module approx_add_core: purely combinational.
//     (a, b, mode, k_eff) -> {approx_sum, exact_sum}.
//     Reusable by the multiplier partial-product trees.
//   - Top level: stage registers, valid chain, stall logic, error abs/diff, stats registers.
// TESTING  (WIDTH=8, APPROX_MAX=4, STAGES=2)
//   1 LOA, k=3, a=0x0F, b=0x01 -> out_sum=0x00F, out_err=1, at cycle t+2; err_cnt=1
//   2 LOA, k=3, a=0xFF, b=0xFF -> out_sum=0x1FF, out_err=1. Then TRUNC, k=3, a=0x07, b=0x07
//     -> out_sum=0x000, out_err=14. Result: err_max=14, err_cnt=2
//   3 EXACT, or k=0, or mode=3, 256 random pairs -> out_sum=a+b, out_err=0, err_cnt unchanged.
//     in_k=7 behaves as k=4
//   4 Back-pressure: stream 8 beats, out_ready low for 3 cycles mid-stream ->
//     in_ready=0 while stalled, out_sum stable, all 8 results in order, none lost or duplicated
//   5 stats_clr in the same cycle as a delivery with out_err=5 -> err_cnt=0, err_max=0 next cycle
//   6 Assert rst with 2 beats in flight -> out_valid=0 immediately.
//     After release, no stale beat is emitted; stats=0

Source files
------------

// File: rtl/approx_add_pkg.sv
// Shared types and helpers for the approximate adder family.
package approx_add_pkg;

   typedef enum logic [1:0] {
      MODE_EXACT = 2'd0,
      MODE_LOA   = 2'd1,
      MODE_TRUNC = 2'd2,
      MODE_RSVD  = 2'd3
   } mode_e;

   // Ceiling log2, usable in parameter expressions.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/approx_add_core.sv
// Combinational approximate/exact adder pair; k_i must already be clamped to WIDTH-1 or less.
module approx_add_core
   import approx_add_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int KW    = 3
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  mode_e            mode_i,
   input  logic [KW-1:0]    k_i,
   output logic [WIDTH:0]   approx_o,
   output logic [WIDTH:0]   exact_o
);

   logic [WIDTH-1:0] lo_mask;
   logic [WIDTH-1:0] top_bit;
   logic [WIDTH-1:0] a_hi;
   logic [WIDTH-1:0] b_hi;
   logic             cin;

   always_comb begin
      exact_o  = {1'b0, a_i} + {1'b0, b_i};
      lo_mask  = (WIDTH'(1) << k_i) - WIDTH'(1);
      top_bit  = (k_i == '0) ? '0 : (WIDTH'(1) << (k_i - KW'(1)));
      a_hi     = a_i & ~lo_mask;
      b_hi     = b_i & ~lo_mask;
      // LOA carry-in is the AND of the top approximate bit pair.
      cin      = |(a_i & b_i & top_bit);
      approx_o = exact_o;
      if (k_i != '0) begin
         case (mode_i)
            MODE_LOA: approx_o = ({1'b0, a_hi} + {1'b0, b_hi} + ((WIDTH+1)'(cin) << k_i))
                                 | {1'b0, (a_i | b_i) & lo_mask};
            MODE_TRUNC: approx_o = {1'b0, a_hi} + {1'b0, b_hi};
            default: approx_o = exact_o;
         endcase
      end
   end

endmodule

// File: rtl/approx_add_pipe.sv
// Pipelined approximate adder with run-time mode/k selection, per-result error and
// on-line error statistics.
module approx_add_pipe
   import approx_add_pkg::*;
#(
   parameter  int WIDTH      = 8,
   parameter  int APPROX_MAX = 4,
   parameter  int STAGES     = 2,
   parameter  int CNT_W      = 16,
   localparam int KW         = clog2(APPROX_MAX + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [1:0]       in_mode,
   input  logic [KW-1:0]    in_k,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   out_sum,
   output logic [WIDTH:0]   out_err,
   input  logic             stats_clr,
   output logic [CNT_W-1:0] err_cnt,
   output logic [WIDTH:0]   err_max
);

   // Handshake: adv = ~out_valid | out_ready moves every stage at once (bubbles kept);
   // a beat enters on in_valid & in_ready and leaves on out_valid & out_ready.
   logic adv;
   logic deliver;

   logic [KW-1:0]  k_eff;
   logic [WIDTH:0] approx_c;
   logic [WIDTH:0] exact_c;

   logic           vld_q  [STAGES];
   logic [WIDTH:0] sum_q  [STAGES];
   logic [WIDTH:0] side_q [STAGES];
   logic           vld_d  [STAGES];
   logic [WIDTH:0] sum_d  [STAGES];
   logic [WIDTH:0] side_d [STAGES];
   logic [WIDTH:0] ex_in  [STAGES];

   logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
   logic [WIDTH:0]   err_max_q, err_max_d;

   assign adv      = ~out_valid | out_ready;
   assign in_ready = adv;
   assign deliver  = out_valid & out_ready;

   always_comb begin
      k_eff = (in_k > KW'(APPROX_MAX)) ? KW'(APPROX_MAX) : in_k;
   end

   approx_add_core #(
      .WIDTH (WIDTH),
      .KW    (KW)
   ) u_core (
      .a_i      (in_a),
      .b_i      (in_b),
      .mode_i   (mode_e'(in_mode)),
      .k_i      (k_eff),
      .approx_o (approx_c),
      .exact_o  (exact_c)
   );

   // side_q carries the exact shadow sum through inner stages and |exact - approx|
   // in the last stage, so the error is registered alongside its sum.
   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      if (s == 0) begin : g_first
         assign vld_d[s] = in_valid;
         assign sum_d[s] = approx_c;
         assign ex_in[s] = exact_c;
      end else begin : g_next
         assign vld_d[s] = vld_q[s-1];
         assign sum_d[s] = sum_q[s-1];
         assign ex_in[s] = side_q[s-1];
      end
      if (s == STAGES - 1) begin : g_err
         assign side_d[s] = (ex_in[s] >= sum_d[s]) ? (ex_in[s] - sum_d[s])
                                                   : (sum_d[s] - ex_in[s]);
      end else begin : g_shadow
         assign side_d[s] = ex_in[s];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < STAGES; s++) begin
            vld_q[s]  <= 1'b0;
            sum_q[s]  <= '0;
            side_q[s] <= '0;
         end
      end else if (adv) begin
         for (int s = 0; s < STAGES; s++) begin
            vld_q[s]  <= vld_d[s];
            sum_q[s]  <= sum_d[s];
            side_q[s] <= side_d[s];
         end
      end
   end

   assign out_valid = vld_q[STAGES-1];
   assign out_sum   = sum_q[STAGES-1];
   assign out_err   = side_q[STAGES-1];

   // Clear wins over a same-cycle delivery; that delivery is dropped from the stats.
   always_comb begin
      err_cnt_d = err_cnt_q;
      err_max_d = err_max_q;
      if (stats_clr) begin
         err_cnt_d = '0;
         err_max_d = '0;
      end else if (deliver) begin
         if ((out_err != '0) && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + CNT_W'(1);
         if (out_err > err_max_q) err_max_d = out_err;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt_q <= '0;
         err_max_q <= '0;
      end else begin
         err_cnt_q <= err_cnt_d;
         err_max_q <= err_max_d;
      end
   end

   assign err_cnt = err_cnt_q;
   assign err_max = err_max_q;

endmodule

// File: tb/tb_approx_add_pipe.sv
// Directed bench for approx_add_pipe (WIDTH=8, APPROX_MAX=4, STAGES=2).
module tb_approx_add_pipe;

   localparam int WIDTH      = 8;
   localparam int APPROX_MAX = 4;
   localparam int STAGES     = 2;
   localparam int CNT_W      = 16;
   localparam int KW         = 3;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [1:0]       in_mode;
   logic [KW-1:0]    in_k;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH:0]   out_sum;
   logic [WIDTH:0]   out_err;
   logic             stats_clr;
   logic [CNT_W-1:0] err_cnt;
   logic [WIDTH:0]   err_max;

   int n_tests = 0;
   int n_fail  = 0;

   // Scoreboard entries are {expected out_sum, expected out_err}.
   logic [2*WIDTH+1:0] exp_q[$];
   logic [WIDTH:0]     held;

   approx_add_pipe #(
      .WIDTH      (WIDTH),
      .APPROX_MAX (APPROX_MAX),
      .STAGES     (STAGES),
      .CNT_W      (CNT_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_mode   (in_mode),
      .in_k      (in_k),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_err   (out_err),
      .stats_clr (stats_clr),
      .err_cnt   (err_cnt),
      .err_max   (err_max)
   );

   // Clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      n_fail++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Driver: presents one beat and returns #1 after the edge that accepts it.
   task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [1:0] m,
                       input logic [2:0] k, input logic [8:0] es, input logic [8:0] ee);
      int waited;
      waited = 0;
      exp_q.push_back({es, ee});
      in_a     = a;
      in_b     = b;
      in_mode  = m;
      in_k     = k;
      in_valid = 1'b1;
      @(negedge clk);
      while (!in_ready && waited < 50) begin
         waited++;
         @(negedge clk);
      end
      if (!in_ready) begin
         n_tests++;
         n_fail++;
         $error("FAIL send_timeout: in_ready stayed %0b for %0d cycles", in_ready, waited);
      end
      @(posedge clk);
      #1 in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int w;
      w = 0;
      while (exp_q.size() != 0 && w < 40) begin
         @(negedge clk);
         w++;
      end
      check({"drain_", tag}, exp_q.size(), 0);
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every delivered beat must match the oldest expectation.
   always @(negedge clk) begin
      logic [2*WIDTH+1:0] e;
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL unexpected_beat: observed sum %0h err %0h, expected no beat",
                   out_sum, out_err);
         end else begin
            e = exp_q.pop_front();
            check("beat_sum", out_sum, e[2*WIDTH+1:WIDTH+1]);
            check("beat_err", out_err, e[WIDTH:0]);
         end
      end
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_mode   = '0;
      in_k      = '0;
      out_ready = 1'b1;
      stats_clr = 1'b0;
      held      = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_sum", out_sum, 0);
      check("rst_out_err", out_err, 0);
      check("rst_err_cnt", err_cnt, 0);
      check("rst_err_max", err_max, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // 1: LOA k=3, 0x0F + 0x01, two-cycle latency
      exp_q.push_back({9'h00F, 9'd1});
      in_a = 8'h0F; in_b = 8'h01; in_mode = 2'd1; in_k = 3'd3; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      check("t1_out_valid_t1", out_valid, 0);
      @(posedge clk);
      #1;
      check("t1_out_valid_t2", out_valid, 1);
      check("t1_out_sum", out_sum, 9'h00F);
      @(posedge clk);
      #1;
      check("t1_err_cnt", err_cnt, 1);
      check("t1_err_max", err_max, 1);
      check("t1_out_valid_after", out_valid, 0);

      stats_clr = 1'b1;
      @(posedge clk);
      #1 stats_clr = 1'b0;
      check("clr_err_cnt", err_cnt, 0);
      check("clr_err_max", err_max, 0);

      // 2: LOA carry out, then TRUNC discarding low bits
      send(8'hFF, 8'hFF, 2'd1, 3'd3, 9'h1FF, 9'd1);
      send(8'h07, 8'h07, 2'd2, 3'd3, 9'h000, 9'd14);
      drain("t2");
      check("t2_err_cnt", err_cnt, 2);
      check("t2_err_max", err_max, 14);

      // 3: exact paths (mode 0, k=0, mode 3) on random operands
      for (int i = 0; i < 256; i++) begin
         logic [7:0] a, b;
         logic [1:0] m;
         logic [2:0] k;
         a = 8'($urandom_range(0, 255));
         b = 8'($urandom_range(0, 255));
         case (i % 4)
            0: begin m = 2'd0; k = 3'($urandom_range(0, 7)); end
            1: begin m = 2'd1; k = 3'd0; end
            2: begin m = 2'd2; k = 3'd0; end
            default: begin m = 2'd3; k = 3'($urandom_range(0, 7)); end
         endcase
         send(a, b, m, k, {1'b0, a} + {1'b0, b}, 9'd0);
      end
      drain("t3");
      check("t3_err_cnt", err_cnt, 2);
      check("t3_err_max", err_max, 14);

      // k above APPROX_MAX clamps to 4; LOA result above the exact sum
      send(8'h0F, 8'h0F, 2'd2, 3'd7, 9'h000, 9'd30);
      send(8'h18, 8'h08, 2'd1, 3'd4, 9'h028, 9'd8);
      send(8'h18, 8'h08, 2'd1, 3'd7, 9'h028, 9'd8);
      drain("kclamp");
      check("kclamp_err_cnt", err_cnt, 5);
      check("kclamp_err_max", err_max, 30);

      // 4: back-pressure for three cycles mid-stream
      fork
         begin
            for (int i = 0; i < 8; i++)
               send(8'(i * 17), 8'h20, 2'd0, 3'd0, 9'(i * 17 + 32), 9'd0);
         end
         begin
            repeat (4) @(posedge clk);
            #1 out_ready = 1'b0;
            held = out_sum;
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               check("t4_in_ready_stall", in_ready, 0);
               check("t4_out_valid_stall", out_valid, 1);
               check("t4_out_sum_stable", out_sum, held);
               @(posedge clk);
               #1;
            end
            check("t4_out_sum_stable_end", out_sum, held);
            out_ready = 1'b1;
         end
      join
      drain("t4");
      check("t4_err_cnt", err_cnt, 5);

      // 5: clear coincides with delivery of an err=5 beat
      send(8'h05, 8'h00, 2'd2, 3'd3, 9'h000, 9'd5);
      @(posedge clk);
      #1;
      check("t5_out_valid", out_valid, 1);
      check("t5_out_err", out_err, 5);
      stats_clr = 1'b1;
      @(posedge clk);
      #1 stats_clr = 1'b0;
      check("t5_err_cnt", err_cnt, 0);
      check("t5_err_max", err_max, 0);
      check("t5_queue", exp_q.size(), 0);

      // 6: reset with two beats in flight
      send(8'h07, 8'h07, 2'd2, 3'd3, 9'h000, 9'd14);
      drain("t6_pre");
      check("t6_pre_err_cnt", err_cnt, 1);
      check("t6_pre_err_max", err_max, 14);
      send(8'h01, 8'h02, 2'd0, 3'd0, 9'h003, 9'd0);
      send(8'h03, 8'h04, 2'd0, 3'd0, 9'h007, 9'd0);
      rst = 1'b1;
      #1;
      check("t6_out_valid_async", out_valid, 0);
      check("t6_err_cnt_async", err_cnt, 0);
      check("t6_err_max_async", err_max, 0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      for (int j = 0; j < 5; j++) begin
         @(negedge clk);
         check("t6_no_stale", out_valid, 0);
      end
      check("t6_err_cnt", err_cnt, 0);
      check("t6_err_max", err_max, 0);
      @(posedge clk);
      #1;
      send(8'h11, 8'h22, 2'd0, 3'd0, 9'h033, 9'd0);
      drain("t6_post");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
